fifo_pixel_reader: RTL

- Read-side companion to fifo_sync: drains the FIFO read port (rd_en/data_rd/empty) and presents pixels as a valid/ready stream.
- Tags each pixel with start-of-frame and end-of-line markers from programmed line geometry.
- Sits between a fifo_sync instance and downstream image-processing stages.
- Hides the FIFO's 1-cycle read latency behind a 2-entry output buffer, so it sustains 1 pixel/cycle under continuous m_ready.

---
 rtl/img_stream_pkg.sv | 15 +
 rtl/stream_skid_buf.sv | 44 ++++
 rtl/fifo_pixel_reader.sv | 89 ++++++++
 3 files changed

// File: rtl/img_stream_pkg.sv
// Shared definitions for pixel-stream blocks: default frame geometry and
// position-counter sizing.
package img_stream_pkg;

  localparam int DEF_LINE_W    = 640;
  localparam int DEF_NUM_LINES = 480;

  typedef logic [1:0] occ_t;

  // Counter width for a modulo-n position counter; never narrower than 1 bit.
  function automatic int pos_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer that absorbs the FIFO read latency in front of a
// valid/ready output.
module stream_skid_buf
  import img_stream_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output occ_t              occ
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_pixel_reader.sv
// Drains a fifo_sync read port into a valid/ready pixel stream tagged with
// start-of-frame / end-of-line markers and a frame-done pulse.
module fifo_pixel_reader
  import img_stream_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int LINE_W    = DEF_LINE_W,
  parameter int NUM_LINES = DEF_NUM_LINES
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              en,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data_rd,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eol,
  output logic              frame_done
);

  localparam int COL_W = pos_w(LINE_W);
  localparam int ROW_W = pos_w(NUM_LINES);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_LINES - 1);

  occ_t              occ;
  logic              inflight;
  logic              pop;
  logic [DATA_W-1:0] head_data;
  logic [2:0]        credits_used;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              col_last;
  logic              row_last;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? head_data : '0;

  // Slots already spoken for after this cycle's pop: held pixels plus the
  // read whose data lands this cycle. A new read needs one slot free.
  assign credits_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en   = aresetn && en && !fifo_empty && (credits_used < 3'd2);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) inflight <= 1'b0;
    else          inflight <= fifo_rd_en;
  end

  stream_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .aresetn   (aresetn),
    .push      (inflight),
    .push_data (fifo_data_rd),
    .pop       (pop),
    .head_data (head_data),
    .occ       (occ)
  );

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && col_last && row_last;
      if (pop) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign m_sof = m_valid && (col == '0) && (row == '0);
  assign m_eol = m_valid && col_last;

endmodule
